// File: rtl/franken_uart_tx_if.sv
// franken_uart_tx_if: core store/load bus as seen by the memory-mapped UART transmitter.
interface franken_uart_tx_if;
    logic        mem_write;
    logic [3:0]  byte_enable;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        rbusy;
    modport master (output mem_write, byte_enable, addr, write_data, input read_data, rbusy);
    modport slave (input mem_write, byte_enable, addr, write_data, output read_data, rbusy);
endinterface

// File: rtl/franken_uart_tx.sv
// franken_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO, stall output and status word.
module franken_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [31:0] TX_ADDR      = 32'h0000_1000,
    parameter logic [31:0] STAT_ADDR    = 32'h0000_1004,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    franken_uart_tx_if.slave bus,
    output logic             TXD
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n, head;
    logic          txd_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow, baud_end, have_data, pop, push_req, push, clear;
    logic          unused_bits;
    assign unused_bits = ^{bus.write_data[31:8], bus.byte_enable[3:1]};
    assign have_data   = count != '0;
    assign baud_end    = baud == BAUD_MAX;
    assign head        = mem[rd_ptr];
    assign push_req    = bus.mem_write && bus.addr == TX_ADDR && bus.byte_enable[0];
    // A full FIFO still takes a byte when the transmitter pops on the same edge.
    assign push        = push_req && (count != FULL || pop);
    assign clear       = bus.mem_write && bus.addr == STAT_ADDR && bus.byte_enable[0] && bus.write_data[2];
    assign bus.rbusy   = count == FULL;
    assign bus.read_data = bus.addr == STAT_ADDR ?
                           {29'b0, overflow, bus.rbusy, state != IDLE || have_data} : '0;
    always_comb begin
        state_n = state;
        baud_n  = baud_end ? '0 : baud + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift;
        txd_n   = TXD;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (have_data) begin
                    pop     = 1'b1;
                    shift_n = head;
                    txd_n   = 1'b0;
                    state_n = START;
                end
            end
            START: if (baud_end) begin
                txd_n   = shift[0];
                bit_n   = '0;
                state_n = DATA;
            end
            DATA: if (baud_end) begin
                if (bit_cnt == 3'd7) begin
                    txd_n   = 1'b1;
                    state_n = STOP;
                end else begin
                    shift_n = shift >> 1;
                    txd_n   = shift[1];
                    bit_n   = bit_cnt + 3'd1;
                end
            end
            STOP: if (baud_end) begin
                pop     = have_data;
                shift_n = head;
                txd_n   = !have_data;
                state_n = have_data ? START : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            TXD     <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            TXD     <= txd_n;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            overflow <= (push_req && !push) ? 1'b1 : clear ? 1'b0 : overflow;
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.write_data[7:0];
endmodule

// File: tb/tb_franken_uart_tx.sv
// tb_franken_uart_tx: directed scenarios for franken_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_franken_uart_tx;
    localparam logic [31:0] TX   = 32'h0000_1000;
    localparam logic [31:0] STAT = 32'h0000_1004;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic txd;
    int   errors = 0;
    int   checks = 0;
    franken_uart_tx_if bus ();
    franken_uart_tx #(.CLKS_PER_BIT(4), .TX_ADDR(TX), .STAT_ADDR(STAT), .FIFO_DEPTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave),
        .TXD  (txd)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    task automatic load_stat();
        bus.mem_write   = 1'b0;
        bus.byte_enable = 4'b0000;
        bus.addr        = STAT;
        bus.write_data  = '0;
    endtask
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.mem_write   = 1'b1;
        bus.byte_enable = be;
        bus.addr        = a;
        bus.write_data  = d;
    endtask
    // Checks 40 consecutive cycles starting at the current negedge, leaving us on the cycle after the frame.
    task automatic check_frame(input logic [7:0] d);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (txd !== f[i/4]) begin
                errors++;
                $display("FAIL frame %h cycle %0d: txd=%b expected %b", d, i, txd, f[i/4]);
            end
            @(negedge clk);
        end
    endtask
    task automatic test_reset();
        load_stat();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: txd=%b expected 1", txd); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || bus.rbusy !== 1'b0 || bus.read_data !== 32'h0) begin
                errors++;
                $display("FAIL idle cycle %0d: txd=%b rbusy=%b status=%h expected 1 0 00000000",
                         i, txd, bus.rbusy, bus.read_data);
            end
        end
    endtask
    task automatic test_single();
        store(TX, 32'h0000_0055, 4'b0001);
        @(negedge clk);
        load_stat();
        #1;
        checks++;
        if (txd !== 1'b1 || bus.read_data !== 32'h1) begin
            errors++;
            $display("FAIL single_push: txd=%b status=%h expected 1 00000001", txd, bus.read_data);
        end
        @(negedge clk);
        check_frame(8'h55);
        checks++;
        if (txd !== 1'b1 || bus.read_data !== 32'h0) begin
            errors++;
            $display("FAIL single_done: txd=%b status=%h expected 1 00000000", txd, bus.read_data);
        end
    endtask
    task automatic test_back_to_back();
        store(TX, 32'h01, 4'b0001);
        @(negedge clk);
        store(TX, 32'h02, 4'b0001);
        @(negedge clk);
        fork
            begin
                for (int b = 1; b <= 5; b++) check_frame(8'(b));
            end
            begin
                store(TX, 32'h03, 4'b0001);
                @(negedge clk);
                store(TX, 32'h04, 4'b0001);
                @(negedge clk);
                store(TX, 32'h05, 4'b0001);
                @(negedge clk);
                checks++;
                if (bus.rbusy !== 1'b1) begin errors++; $display("FAIL full_rbusy: rbusy=%b expected 1", bus.rbusy); end
                store(TX, 32'h06, 4'b0001);
                @(negedge clk);
                load_stat();
                #1;
                checks++;
                if (bus.read_data !== 32'h7) begin
                    errors++;
                    $display("FAIL overflow_status: status=%h expected 00000007", bus.read_data);
                end
            end
        join
        #1;
        checks++;
        if (txd !== 1'b1 || bus.read_data !== 32'h4) begin
            errors++;
            $display("FAIL b2b_done: txd=%b status=%h expected 1 00000004", txd, bus.read_data);
        end
    endtask
    task automatic test_clear_and_lanes();
        store(STAT, 32'h4, 4'b0001);
        @(negedge clk);
        load_stat();
        #1;
        checks++;
        if (bus.read_data !== 32'h0) begin
            errors++;
            $display("FAIL overflow_clear: status=%h expected 00000000", bus.read_data);
        end
        store(TX, 32'h0000_AA00, 4'b0010);
        @(negedge clk);
        load_stat();
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (txd !== 1'b1 || bus.read_data !== 32'h0) begin
                errors++;
                $display("FAIL lane_ignored cycle %0d: txd=%b status=%h expected 1 00000000", i, txd, bus.read_data);
            end
            @(negedge clk);
        end
    endtask
    task automatic test_push_on_pop();
        store(TX, 32'h11, 4'b0001);
        @(negedge clk);
        store(TX, 32'h22, 4'b0001);
        @(negedge clk);
        fork
            begin
                check_frame(8'h11);
                check_frame(8'h22);
                check_frame(8'h33);
                check_frame(8'h44);
                check_frame(8'h55);
                check_frame(8'h66);
            end
            begin
                store(TX, 32'h33, 4'b0001);
                @(negedge clk);
                store(TX, 32'h44, 4'b0001);
                @(negedge clk);
                store(TX, 32'h55, 4'b0001);
                @(negedge clk);
                load_stat();
                repeat (36) @(negedge clk);
                checks++;
                if (bus.rbusy !== 1'b1) begin errors++; $display("FAIL pre_pop_full: rbusy=%b expected 1", bus.rbusy); end
                store(TX, 32'h66, 4'b0001);
                @(negedge clk);
                load_stat();
                #1;
                checks++;
                if (bus.read_data !== 32'h3) begin
                    errors++;
                    $display("FAIL push_on_pop: status=%h expected 00000003", bus.read_data);
                end
            end
        join
        #1;
        checks++;
        if (txd !== 1'b1 || bus.read_data !== 32'h0) begin
            errors++;
            $display("FAIL push_on_pop_done: txd=%b status=%h expected 1 00000000", txd, bus.read_data);
        end
    endtask
    task automatic test_reset_mid_frame();
        store(TX, 32'hA5, 4'b0001);
        @(negedge clk);
        store(TX, 32'h3C, 4'b0001);
        @(negedge clk);
        load_stat();
        repeat (17) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL data_bit3: txd=%b expected 0", txd); end
        reset = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || bus.read_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: txd=%b status=%h expected 1 00000000", txd, bus.read_data);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || bus.read_data !== 32'h0) begin
                errors++;
                $display("FAIL post_reset cycle %0d: txd=%b status=%h expected 1 00000000", i, txd, bus.read_data);
            end
        end
    endtask
    initial begin
        load_stat();
        test_reset();
        test_single();
        test_back_to_back();
        test_clear_and_lanes();
        test_push_on_pop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/franken_uart_tx.md
Name: franken_uart_tx

Overview:
- Memory-mapped UART transmitter that sits directly downstream of the core's memory stage.
- Consumes the core's store bus (mem_write_Mem, byte_enable, address, write_data), queues bytes in a small FIFO, and serialises them onto TXD (8N1, LSB first).
- Drives the core's rbusy stall input when the FIFO is full.
- Provides a status word for load readback.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- TX_ADDR, 32'h0000_1000, word address of the TX data register.
- STAT_ADDR, 32'h0000_1004, word address of the status register.
- FIFO_DEPTH, 4, number of byte entries; must be a power of 2, ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_write  input  1  store strobe from the core's memory stage.
- byte_enable  input  4  store byte lanes.
- addr  input  32  store/load address (alu result).
- write_data  input  32  store data, lane-aligned.
- read_data  output  32  status readback, combinational on addr.
- TXD  output  1  serial output; idle high.
- rbusy  output  1  high while the FIFO is full; stalls the core.

Behaviour:
- Reset (asynchronous, immediate): TXD=1, rbusy=0, FIFO count=0, read/write pointers=0, overflow=0, FSM=IDLE, baud counter=0, bit counter=0. A reset mid-frame aborts the frame; TXD returns high without waiting for a clock edge.
- Push condition:
  - mem_write=1, addr==TX_ADDR, byte_enable[0]=1; the byte pushed is write_data[7:0].
  - Accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs on the same edge.
  - Otherwise dropped and overflow set to 1 (sticky).
  - A write with byte_enable[0]=0 is ignored.
- Overflow clear: mem_write=1, addr==STAT_ADDR, byte_enable[0]=1, write_data[2]=1. If a clear and a new overflow occur on the same edge, the set wins.
- read_data:
  - addr==STAT_ADDR → {29'b0, overflow, rbusy, tx_active}, where tx_active = (FSM!=IDLE) || (count!=0).
  - Any other addr → 0.
- rbusy = (count==FIFO_DEPTH). Registered from count, so it is valid from the edge on which the FIFO fills.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TXD=1. If count!=0 at an edge: pop the head into the shift register, TXD←0, baud counter←0, go to START. A byte pushed at edge N into an empty FIFO with FSM in IDLE is popped at edge N+1; TXD falls after edge N+1.
  - START: hold TXD=0 for CLKS_PER_BIT cycles. On baud counter==CLKS_PER_BIT-1: TXD←shift[0], bit counter←0, go to DATA.
  - DATA: each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After bit 7 completes: TXD←1, go to STOP.
  - STOP: hold TXD=1 for CLKS_PER_BIT cycles. At the end, if count!=0, pop and go directly to START (TXD←0, no idle gap); else go to IDLE.
- Timing: frame length is exactly 10·CLKS_PER_BIT cycles. Baud counter wraps to 0 at every bit boundary.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. A simultaneous push and pop leaves count unchanged.
- Only the push path and the overflow-clear path depend on mem_write; loads never change state.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset release, no stimulus for 100 cycles → TXD=1 constantly, rbusy=0, read_data@STAT_ADDR=0.
2. Single store of 0x55 to TX_ADDR (byte_enable=4'b0001) → TXD falls 1 cycle after the push edge. Each level is held 4 cycles, sequence 0,1,0,1,0,1,0,1,0,1 (40 cycles total). Then TXD=1 and status=0.
3. Six back-to-back stores 0x01..0x06 →
   - rbusy=1 once the FIFO is full.
   - Store 0x06 is dropped and overflow=1 (status bit2=1).
   - Bytes 0x01..0x05 are transmitted contiguously with no idle cycles between frames (200 cycles).
4. Store to STAT_ADDR with write_data=32'h4 → overflow=0. A store to TX_ADDR with byte_enable=4'b0010 → no push, TXD stays 1.
5. Push into a full FIFO on the STOP→START pop edge → byte accepted, count stays 4, no overflow.
6. Assert reset during DATA bit 3 of 0xA5 → TXD=1 immediately (before the next clk edge), count=0. After release: idle, no residual transmission.
